// File: rtl/cpu_multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle control FSM (master) and the
// unified instruction/data memory (slave).
interface cpu_multicycle_ctrl_if;
    logic memRead;
    logic memWrite;
    logic IorD;
    logic memAck;

    modport master (output memRead, output memWrite, output IorD, input memAck);
    modport slave  (input memRead, input memWrite, input IorD, output memAck);
endinterface

// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute and drives datapath selects.
// Optional overflow trap on ADD/SUB/ADDI writeback is enabled by defining OVERFLOW_TRAP_EN.
module cpu_multicycle_ctrl #(
    parameter int ALUOpeLen = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_multicycle_ctrl_if.master mem,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zeroFlag,
    input  logic                  overflowFlag,
    output logic                  IRWrite,
    output logic                  PCEn,
    output logic [1:0]            PCSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALUOpeLen-1:0]  ALUOpe,
    output logic                  regDst,
    output logic                  memToReg,
    output logic                  regWrite,
    output logic                  illegalOp,
    output logic                  excepted
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC     = 4'd3;
    localparam logic [3:0] S_ALUWB    = 4'd4;
    localparam logic [3:0] S_MEMADDR  = 4'd5;
    localparam logic [3:0] S_MEMRD    = 4'd6;
    localparam logic [3:0] S_MEMWB    = 4'd7;
    localparam logic [3:0] S_MEMWR    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_ADDIEXEC = 4'd10;
    localparam logic [3:0] S_ADDIWB   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_ILLEGAL  = 4'd13;
`ifdef OVERFLOW_TRAP_EN
    localparam logic [3:0] S_TRAP     = 4'd14;
`endif

    localparam logic [ALUOpeLen-1:0] OP_AND = ALUOpeLen'(4'b0000);
    localparam logic [ALUOpeLen-1:0] OP_OR  = ALUOpeLen'(4'b0001);
    localparam logic [ALUOpeLen-1:0] OP_ADD = ALUOpeLen'(4'b0010);
    localparam logic [ALUOpeLen-1:0] OP_XOR = ALUOpeLen'(4'b0011);
    localparam logic [ALUOpeLen-1:0] OP_SUB = ALUOpeLen'(4'b0110);
    localparam logic [ALUOpeLen-1:0] OP_SLT = ALUOpeLen'(4'b0111);
    localparam logic [ALUOpeLen-1:0] OP_NOR = ALUOpeLen'(4'b1100);

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;

    logic [3:0] state_q, state_d;

    logic                 memRead, memWrite, IorD;
    logic [ALUOpeLen-1:0] func_op;
    logic                 func_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        func_op    = OP_ADD;
        func_valid = 1'b1;
        case (funct)
            6'b100000: func_op = OP_ADD;
            6'b100010: func_op = OP_SUB;
            6'b100100: func_op = OP_AND;
            6'b100101: func_op = OP_OR;
            6'b100110: func_op = OP_XOR;
            6'b100111: func_op = OP_NOR;
            6'b101010: func_op = OP_SLT;
            default:   func_valid = 1'b0;
        endcase
    end

`ifdef OVERFLOW_TRAP_EN
    logic func_arith;
    assign func_arith = (funct == 6'b100000) || (funct == 6'b100010);
`else
    logic unused_overflow;
    assign unused_overflow = overflowFlag;
`endif

    always_comb begin
        state_d   = state_q;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCEn      = 1'b0;
        PCSrc     = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOpe    = OP_ADD;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        regWrite  = 1'b0;
        illegalOp = 1'b0;
        excepted  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // IDLE is the reset state, so every output including ALUOpe must read 0
                ALUOpe  = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                memRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem.memAck;
                PCEn    = mem.memAck;
                if (mem.memAck) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OPC_RTYPE:       state_d = S_EXEC;
                    OPC_LW, OPC_SW:  state_d = S_MEMADDR;
                    OPC_BEQ, OPC_BNE: state_d = S_BRANCH;
                    OPC_ADDI:        state_d = S_ADDIEXEC;
                    OPC_J:           state_d = S_JUMP;
                    default:         state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                if (func_valid) begin
                    ALUOpe  = func_op;
                    state_d = S_ALUWB;
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
                state_d  = S_FETCH;
`ifdef OVERFLOW_TRAP_EN
                // Hold the EXEC operands so overflowFlag still reflects this instruction
                if (func_arith) begin
                    ALUSrcA = 1'b1;
                    ALUOpe  = func_op;
                    if (overflowFlag) begin
                        regWrite = 1'b0;
                        state_d  = S_TRAP;
                    end
                end
`endif
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OPC_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                IorD    = 1'b1;
                if (mem.memAck) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                IorD     = 1'b1;
                if (mem.memAck) state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOpe  = OP_SUB;
                PCSrc   = 2'b01;
                PCEn    = (opcode == OPC_BNE) ? !zeroFlag : zeroFlag;
                state_d = S_FETCH;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
`ifdef OVERFLOW_TRAP_EN
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (overflowFlag) begin
                    regWrite = 1'b0;
                    state_d  = S_TRAP;
                end
`endif
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCEn    = 1'b1;
                state_d = S_FETCH;
            end
            S_ILLEGAL: begin
                illegalOp = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef OVERFLOW_TRAP_EN
            S_TRAP: begin
                PCSrc    = 2'b11;
                PCEn     = 1'b1;
                excepted = 1'b1;
                state_d  = S_FETCH;
            end
`endif
            default: begin
                ALUOpe  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem.memRead  = memRead;
    assign mem.memWrite = memWrite;
    assign mem.IorD     = IorD;

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Directed + randomized bench for cpu_multicycle_ctrl; expected output traces are
// generated per instruction class from the behavioural rules, then replayed cycle by cycle.
module tb_cpu_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zeroFlag, overflowFlag;
    logic       IRWrite, PCEn, ALUSrcA, regDst, memToReg, regWrite, illegalOp, excepted;
    logic [1:0] PCSrc, ALUSrcB;
    logic [3:0] ALUOpe;

    int checks = 0;
    int errors = 0;

    cpu_multicycle_ctrl_if ifc ();

    cpu_multicycle_ctrl #(.ALUOpeLen(4)) dut (
        .clk(clk), .rst(rst), .mem(ifc.master),
        .opcode(opcode), .funct(funct), .zeroFlag(zeroFlag), .overflowFlag(overflowFlag),
        .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOpe(ALUOpe), .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
        .illegalOp(illegalOp), .excepted(excepted)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010;

    typedef struct packed {
        logic        ack;
        logic        zf;
        logic        ovf;
        logic [18:0] exp;
    } step_t;

    step_t q[$];
    string tq[$];

    function automatic logic [18:0] ov(input logic mr, mw, iord, irw, pce, input logic [1:0] pcs,
                                       input logic asa, input logic [1:0] asb, input logic [3:0] aop,
                                       input logic rd, m2r, rw, ill, exc);
        return {mr, mw, iord, irw, pce, pcs, asa, asb, aop, rd, m2r, rw, ill, exc};
    endfunction

    function automatic logic [18:0] observed();
        return {ifc.memRead, ifc.memWrite, ifc.IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                ALUOpe, regDst, memToReg, regWrite, illegalOp, excepted};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic fvalid(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
    endfunction

    function automatic logic [3:0] fop(input logic [5:0] f);
        case (f)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100110: return 4'b0011;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    task automatic push(input logic ack, zf, ovf, input logic [18:0] e, input string t);
        q.push_back('{ack: ack, zf: zf, ovf: ovf, exp: e});
        tq.push_back(t);
    endtask

    task automatic check(input logic [18:0] exp, input string t);
        logic [18:0] got;
        got = observed();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", t, got, exp);
        end
    endtask

    task automatic do_step();
        step_t s;
        string t;
        s = q.pop_front();
        t = tq.pop_front();
        ifc.memAck = s.ack; zeroFlag = s.zf; overflowFlag = s.ovf;
        #1;
        check(s.exp, t);
        @(posedge clk); #1;
    endtask

    task automatic trap_step();
        push(rb(), rb(), rb(), ov(0,0,0,0,1,2'b11,0,2'b00,ADD,0,0,0,0,1), "trap");
    endtask

    // Expected cycle trace of one instruction, from FETCH until the return to FETCH.
    task automatic build(input logic [5:0] op, fn, input int fw, mw, input logic zf, ovf);
        for (int i = 0; i < fw; i++)
            push(1'b0, rb(), rb(), ov(1,0,0,0,0,2'b00,0,2'b01,ADD,0,0,0,0,0), "fetch_wait");
        push(1'b1, rb(), rb(), ov(1,0,0,1,1,2'b00,0,2'b01,ADD,0,0,0,0,0), "fetch_ack");
        push(rb(), rb(), rb(), ov(0,0,0,0,0,2'b00,0,2'b11,ADD,0,0,0,0,0), "decode");
        case (op)
            6'b000000: begin
                if (fvalid(fn)) begin
                    push(rb(), rb(), rb(), ov(0,0,0,0,0,2'b00,1,2'b00,fop(fn),0,0,0,0,0), "exec");
`ifdef OVERFLOW_TRAP_EN
                    if (fn == 6'b100000 || fn == 6'b100010) begin
                        push(rb(), rb(), ovf, ov(0,0,0,0,0,2'b00,1,2'b00,fop(fn),1,0,!ovf,0,0), "aluwb");
                        if (ovf) trap_step();
                    end else
                        push(rb(), rb(), rb(), ov(0,0,0,0,0,2'b00,0,2'b00,ADD,1,0,1,0,0), "aluwb");
`else
                    push(rb(), rb(), ovf, ov(0,0,0,0,0,2'b00,0,2'b00,ADD,1,0,1,0,0), "aluwb");
`endif
                end else begin
                    push(rb(), rb(), rb(), ov(0,0,0,0,0,2'b00,1,2'b00,ADD,0,0,0,0,0), "exec_bad");
                    push(rb(), rb(), rb(), ov(0,0,0,0,0,2'b00,0,2'b00,ADD,0,0,0,1,0), "illegal_funct");
                end
            end
            LW, SW: begin
                push(rb(), rb(), rb(), ov(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0,0), "memaddr");
                for (int i = 0; i <= mw; i++) begin
                    if (op == LW)
                        push(i == mw, rb(), rb(), ov(1,0,1,0,0,2'b00,0,2'b00,ADD,0,0,0,0,0), "memrd");
                    else
                        push(i == mw, rb(), rb(), ov(0,1,1,0,0,2'b00,0,2'b00,ADD,0,0,0,0,0), "memwr");
                end
                if (op == LW)
                    push(rb(), rb(), rb(), ov(0,0,0,0,0,2'b00,0,2'b00,ADD,0,1,1,0,0), "memwb");
            end
            BEQ, BNE: begin
                push(rb(), zf, rb(), ov(0,0,0,0,(op == BEQ) ? zf : !zf,2'b01,1,2'b00,SUB,0,0,0,0,0), "branch");
            end
            ADDI: begin
                push(rb(), rb(), rb(), ov(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0,0), "addiexec");
`ifdef OVERFLOW_TRAP_EN
                push(rb(), rb(), ovf, ov(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,!ovf,0,0), "addiwb");
                if (ovf) trap_step();
`else
                push(rb(), rb(), ovf, ov(0,0,0,0,0,2'b00,0,2'b00,ADD,0,0,1,0,0), "addiwb");
`endif
            end
            J: push(rb(), rb(), rb(), ov(0,0,0,0,1,2'b10,0,2'b00,ADD,0,0,0,0,0), "jump");
            default: push(rb(), rb(), rb(), ov(0,0,0,0,0,2'b00,0,2'b00,ADD,0,0,0,1,0), "illegal_op");
        endcase
    endtask

    task automatic instr(input logic [5:0] op, fn, input int fw, mw, input logic zf, ovf);
        opcode = op; funct = fn;
        build(op, fn, fw, mw, zf, ovf);
        while (q.size() > 0) do_step();
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] op, fn;
        ops = '{6'b000000, LW, SW, BEQ, BNE, ADDI, J, 6'b111111};
        rst = 1'b1; opcode = '0; funct = '0; zeroFlag = 0; overflowFlag = 0; ifc.memAck = 0;
        @(posedge clk); @(posedge clk); #1;
        check(19'b0, "reset_state");
        rst = 1'b0; #1;
        check(19'b0, "idle");
        @(posedge clk); #1;

        instr(6'b000000, 6'b100111, 3, 0, 0, 0);
        instr(6'b000000, 6'b111111, 0, 0, 0, 0);
        instr(BEQ, 6'h00, 1, 0, 1, 0);
        instr(BNE, 6'h00, 0, 0, 1, 0);
        instr(BEQ, 6'h00, 0, 0, 0, 0);
        instr(BNE, 6'h00, 0, 0, 0, 0);
        instr(SW, 6'h15, 0, 2, 0, 0);
        instr(ADDI, 6'h3f, 0, 0, 0, 1);
        instr(ADDI, 6'h3f, 1, 0, 0, 0);
        instr(6'b000000, 6'b100000, 0, 0, 0, 1);
        instr(6'b000000, 6'b100010, 0, 0, 0, 0);
        instr(6'b000000, 6'b101010, 0, 0, 0, 1);
        instr(LW, 6'h01, 2, 1, 0, 0);
        instr(J, 6'h00, 0, 0, 0, 0);
        instr(6'b111111, 6'h20, 0, 0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : 6'b100000 | 6'($urandom_range(0, 10));
            instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), rb(), rb());
        end

        // Asynchronous reset while a load is waiting for memory
        opcode = LW; funct = 6'h00;
        build(LW, 6'h00, 0, 4, 0, 0);
        for (int i = 0; i < 4; i++) do_step();
        q.delete(); tq.delete();
        ifc.memAck = 1'b0; #1;
        check(ov(1,0,1,0,0,2'b00,0,2'b00,ADD,0,0,0,0,0), "memrd_before_rst");
        rst = 1'b1; #1;
        check(19'b0, "rst_mid_memrd");
        @(posedge clk); #1;
        check(19'b0, "rst_held");
        rst = 1'b0; #1;
        check(19'b0, "idle_after_rst");
        @(posedge clk); #1;
        check(ov(1,0,0,0,0,2'b00,0,2'b01,ADD,0,0,0,0,0), "fetch_after_rst");
        instr(J, 6'h00, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_multicycle_ctrl.md
Name: cpu_multicycle_ctrl

Overview:
- Multi-cycle MIPS control FSM. Decodes the instruction-register fields, sequences each instruction over 3–5+ cycles, and drives all datapath selects.
- Sole producer of the ALU operation code (ALUOpe). Consumes the ALU zeroFlag and overflowFlag.
- Talks to unified instruction/data memory through a req/ack handshake.

Parameters:
- ALUOpeLen, 4, width of ALUOpe. Encodings below assume 4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- opcode  in  6  IR[31:26]. Stable from DECODE until return to FETCH.
- funct  in  6  IR[5:0]. Same stability as opcode.
- zeroFlag  in  1  ALU zero result
- overflowFlag  in  1  ALU signed overflow
- memAck  in  1  memory completes current read/write this cycle
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- IorD  out  1  0 = PC address, 1 = ALUOut address
- IRWrite  out  1  load instruction register
- PCEn  out  1  PC load enable
- PCSrc  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
- ALUOpe  out  ALUOpeLen  ALU operation
- regDst  out  1  0 = rt, 1 = rd
- memToReg  out  1  writeback source is memory data
- regWrite  out  1  register file write enable
- illegalOp  out  1  one-cycle pulse on an undecodable instruction
- excepted  out  1  one-cycle pulse on an overflow trap (only with OVERFLOW_TRAP_EN)

Behaviour:
- ALUOpe encoding:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, NOR 1100.
- Outputs are Moore decodes of state. Exceptions: PCEn in FETCH and BRANCH, and IRWrite in FETCH, are combinational on inputs.
- Any output not listed for a state is 0. ALUOpe defaults to ADD.
- Reset (async, any state, including mid-handshake): state = IDLE, all outputs 0. IDLE goes to FETCH on the next edge.
- FETCH:
  - memRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOpe=ADD, PCSrc=00.
  - IRWrite=PCEn=memAck.
  - Stay in FETCH while memAck=0; go to DECODE when memAck=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOpe=ADD.
  - Dispatch on opcode:
    - 000000 → EXEC
    - 100011 (lw) or 101011 (sw) → MEMADDR
    - 000100 (beq) or 000101 (bne) → BRANCH
    - 001000 (addi) → ADDIEXEC
    - 000010 (j) → JUMP
    - else → ILLEGAL
- EXEC:
  - ALUSrcA=1, ALUSrcB=00, ALUOpe from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
  - Valid funct → ALUWB. Other funct → ILLEGAL.
- ALUWB: regDst=1, memToReg=0, regWrite=1 → FETCH.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOpe=ADD. lw → MEMRD, sw → MEMWR.
- MEMRD: memRead=1, IorD=1. Wait for memAck, then → MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1 → FETCH.
- MEMWR: memWrite=1, IorD=1. Wait for memAck, then → FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOpe=SUB, PCSrc=01.
  - PCEn = zeroFlag (beq) or !zeroFlag (bne).
  - → FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOpe=ADD → ADDIWB.
- ADDIWB: regDst=0, memToReg=0, regWrite=1 → FETCH.
- JUMP: PCSrc=10, PCEn=1 → FETCH.
- ILLEGAL: illegalOp=1 for exactly one cycle → FETCH. PC is not modified.
- Handshake rules:
  - memRead/memWrite stay high every cycle until memAck is sampled high. No timeout.
  - memAck outside FETCH/MEMRD/MEMWR is ignored.
  - memRead and memWrite are never both 1.

Optional Feature:
- Macro: OVERFLOW_TRAP_EN.
- Defined:
  - ALUWB for ADD/SUB and ADDIWB sample overflowFlag. The ALU inputs are held by keeping the EXEC/ADDIEXEC selects and ALUOpe asserted in the WB state.
  - If overflowFlag=1: regWrite is forced 0 → TRAP.
  - TRAP: PCSrc=11, PCEn=1, excepted=1 for one cycle → FETCH.
  - AND/OR/XOR/NOR/SLT never trap.
- Undefined: overflowFlag is ignored, the TRAP state does not exist, and excepted is tied to 0.

Test Plan:
- Reset asserted mid-MEMRD with memRead=1 → all outputs 0 in the same cycle. One cycle after release FETCH asserts memRead=1, ALUOpe=0010.
- FETCH with memAck low 3 cycles, then high → memRead high 4 cycles, IRWrite=PCEn=1 only on cycle 4, DECODE next.
- R-type funct=100111 → EXEC ALUOpe=1100, ALUWB regWrite=1 regDst=1. funct=111111 → illegalOp pulse, back to FETCH, no regWrite.
- beq with zeroFlag=1 → PCEn=1 PCSrc=01 ALUOpe=0110. bne with zeroFlag=1 → PCEn=0.
- sw with memAck after 2 waits → MEMWR memWrite=1 IorD=1 for 3 cycles, regWrite never asserted, then FETCH.
- OVERFLOW_TRAP_EN defined, addi with overflowFlag=1 → ADDIWB regWrite=0, TRAP PCSrc=11 PCEn=1 excepted=1. Macro undefined → regWrite=1, no trap.
